// File: rtl/issue_queue.sv
// issue_queue: in-order instruction buffer between fetch and the reservation
// station. Words are held in a small circular FIFO. One word issues per cycle
// with a wrapping id tag. Issue is gated by reservation-station and ROB
// back-pressure. A flush empties the queue and restarts the id sequence.
module issue_queue #(
    parameter int DEPTH_LOG = 2,
    parameter int ID_WIDTH  = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_pipline,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_ins,
    output logic                 fetch_ready,
    input  logic                 rs_full,
    input  logic                 rob_full,
    output logic                 ins_just_issued,
    output logic [31:0]          ins_issued,
    output logic [ID_WIDTH-1:0]  ins_id,
    output logic [DEPTH_LOG:0]   queue_count
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    localparam logic [DEPTH_LOG-1:0] PTR_ZERO   = {DEPTH_LOG{1'b0}};
    localparam logic [DEPTH_LOG-1:0] PTR_ONE    = {{(DEPTH_LOG-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG:0]   CNT_ZERO   = {(DEPTH_LOG+1){1'b0}};
    localparam logic [DEPTH_LOG:0]   CNT_ONE    = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG:0]   CNT_FULL   = {1'b1, {DEPTH_LOG{1'b0}}};
    localparam logic [ID_WIDTH-1:0]  ID_ZERO    = {ID_WIDTH{1'b0}};
    localparam logic [ID_WIDTH-1:0]  ID_ONE     = {{(ID_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0]          mem_r [DEPTH];
    logic [DEPTH_LOG-1:0] head_r;
    logic [DEPTH_LOG-1:0] tail_r;
    logic [DEPTH_LOG:0]   count_r;
    logic [DEPTH_LOG:0]   count_nxt_s;
    logic [ID_WIDTH-1:0]  next_id_r;
    logic                 empty_s;
    logic                 full_s;
    logic                 push_s;
    logic                 issue_s;

    assign empty_s     = (count_r == CNT_ZERO);
    assign full_s      = (count_r == CNT_FULL);
    // Ready is based on current occupancy only; a same-cycle issue does not free a slot.
    assign fetch_ready = !full_s;
    assign queue_count = count_r;

    assign push_s  = rdy_in && fetch_valid && !full_s && !flush_pipline;
    assign issue_s = rdy_in && !empty_s && !rs_full && !rob_full && !flush_pipline;

    // Occupancy after this edge, ignoring flush (handled in the register block).
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, issue_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array write; contents are only read when the slot is occupied.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_r[tail_r] <= fetch_ins;
        end
    end

    // Pointers, occupancy, id counter and registered issue outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_r          <= PTR_ZERO;
            tail_r          <= PTR_ZERO;
            count_r         <= CNT_ZERO;
            next_id_r       <= ID_ZERO;
            ins_just_issued <= 1'b0;
            ins_issued      <= 32'h0000_0000;
            ins_id          <= ID_ZERO;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                // Flush wins over push and issue; last issued word/id stay visible.
                head_r          <= PTR_ZERO;
                tail_r          <= PTR_ZERO;
                count_r         <= CNT_ZERO;
                next_id_r       <= ID_ZERO;
                ins_just_issued <= 1'b0;
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (issue_s) begin
                    ins_issued      <= mem_r[head_r];
                    ins_id          <= next_id_r;
                    ins_just_issued <= 1'b1;
                    head_r          <= head_r + PTR_ONE;
                    next_id_r       <= next_id_r + ID_ONE;
                end else begin
                    ins_just_issued <= 1'b0;
                end
                count_r <= count_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: a scoreboard of expected issued words, filled when a
// push is driven and drained when an issue is expected, plus a reference id
// counter and occupancy taken from the scoreboard size.
module tb_issue_queue;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        fetch_valid;
    logic [31:0] fetch_ins;
    logic        fetch_ready;
    logic        rs_full;
    logic        rob_full;
    logic        ins_just_issued;
    logic [31:0] ins_issued;
    logic [4:0]  ins_id;
    logic [2:0]  queue_count;

    issue_queue #(.DEPTH_LOG(2), .ID_WIDTH(5)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .flush_pipline   (flush_pipline),
        .fetch_valid     (fetch_valid),
        .fetch_ins       (fetch_ins),
        .fetch_ready     (fetch_ready),
        .rs_full         (rs_full),
        .rob_full        (rob_full),
        .ins_just_issued (ins_just_issued),
        .ins_issued      (ins_issued),
        .ins_id          (ins_id),
        .queue_count     (queue_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] sb_q[$];
    int          m_id       = 0;
    logic        exp_strobe = 1'b0;
    logic [31:0] exp_word   = 32'h0;
    logic [4:0]  exp_id     = 5'd0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, check outputs.
    task automatic step(input logic fv, input logic [31:0] w, input logic rsf,
                        input logic robf, input logic fl, input logic rdy);
        logic acc;
        logic iss;
        fetch_valid   = fv;
        fetch_ins     = w;
        rs_full       = rsf;
        rob_full      = robf;
        flush_pipline = fl;
        rdy_in        = rdy;
        #1;
        check_val("fetch_ready", {31'd0, fetch_ready}, {31'd0, (sb_q.size() < 4)});
        acc = rdy && fv && (sb_q.size() < 4) && !fl;
        iss = rdy && (sb_q.size() > 0) && !rsf && !robf && !fl;
        @(posedge clk_in);
        #1;
        if (rdy) begin
            if (fl) begin
                sb_q.delete();
                m_id       = 0;
                exp_strobe = 1'b0;
            end else begin
                if (iss) begin
                    exp_word   = sb_q.pop_front();
                    exp_id     = m_id[4:0];
                    m_id       = (m_id + 1) % 32;
                    exp_strobe = 1'b1;
                end else begin
                    exp_strobe = 1'b0;
                end
                if (acc) sb_q.push_back(w);
            end
        end
        check_val("strobe", {31'd0, ins_just_issued}, {31'd0, exp_strobe});
        check_val("ins_issued", ins_issued, exp_word);
        check_val("ins_id", {27'd0, ins_id}, {27'd0, exp_id});
        check_val("queue_count", {29'd0, queue_count}, sb_q.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_flush();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush_pipline = 1'b0;
        fetch_valid   = 1'b0;
        fetch_ins     = 32'h0;
        rs_full       = 1'b0;
        rob_full      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check_val("rst_strobe", {31'd0, ins_just_issued}, 32'd0);
        check_val("rst_ins", ins_issued, 32'd0);
        check_val("rst_id", {27'd0, ins_id}, 32'd0);
        check_val("rst_count", {29'd0, queue_count}, 32'd0);
        check_val("rst_ready", {31'd0, fetch_ready}, 32'd1);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Single push then issue with id 0
        step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("single_no_bypass", {31'd0, ins_just_issued}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("single_word", ins_issued, 32'h0050_0093);
        check_val("single_id", {27'd0, ins_id}, 32'd0);
        idle(2);

        // Fill under rs_full, fifth word refused, then drain in order
        do_flush();
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA000_0000 + i, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("fill_count", {29'd0, queue_count}, 32'd4);
        check_val("fill_ready", {31'd0, fetch_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_val("drain_id", {27'd0, ins_id}, i);
        end
        idle(1);

        // Occupancy 3 kept constant by simultaneous push/issue, then long stream for id wrap
        do_flush();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 36; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
            check_val("stream_count", {29'd0, queue_count}, 32'd3);
        end
        idle(4);

        // ROB stall
        for (int i = 0; i < 2; i++) step(1'b1, 32'hB000_0000 + i, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Flush mid-stream with a same-cycle push attempt
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC000_0000 + i, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("flush_count", {29'd0, queue_count}, 32'd0);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("post_flush_id", {27'd0, ins_id}, 32'd0);
        check_val("post_flush_word", ins_issued, 32'h1234_5678);

        // rdy_in pause with an ignored flush pulse
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 2; i++) step(1'b1, 32'hE000_0000 + i, 1'b1, 1'b0, 1'b0, 1'b1);
        rst_in = 1'b0;
        #2;
        check_val("midrst_count", {29'd0, queue_count}, 32'd0);
        check_val("midrst_ready", {31'd0, fetch_ready}, 32'd1);
        check_val("midrst_ins", ins_issued, 32'd0);
        sb_q.delete();
        m_id       = 0;
        exp_strobe = 1'b0;
        exp_word   = 32'h0;
        exp_id     = 5'd0;
        rst_in     = 1'b1;
        step(1'b1, 32'h0ABC_DEF0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Front-end buffer between instruction fetch and the reservation station. Accepts fetched 32-bit instructions, holds them in order in a small FIFO, and issues one per cycle to the reservation station, tagging each with a wrapping 5-bit instruction id. Issue is gated by back-pressure from the reservation station and the reorder buffer. A pipeline flush empties the queue.

## Interface
- DEPTH_LOG, 2, log2 of FIFO depth (default 4 entries)
- ID_WIDTH, 5, width of the instruction id tag
- clk_in  input  1  system clock, all state on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; when low, all state and outputs hold
- flush_pipline  input  1  discard all queued instructions and reset the id counter
- fetch_valid  input  1  fetch presents an instruction this cycle
- fetch_ins  input  32  fetched instruction word
- fetch_ready  output  1  queue can accept; combinational, equals !full
- rs_full  input  1  reservation station cannot accept an instruction this cycle
- rob_full  input  1  reorder buffer has no free entry this cycle
- ins_just_issued  output  1  registered one-cycle issue strobe to the reservation station
- ins_issued  output  32  registered issued instruction word
- ins_id  output  ID_WIDTH  registered id of the issued instruction
- queue_count  output  DEPTH_LOG+1  current occupancy, registered

## Operation
- Storage: circular buffer of 2^DEPTH_LOG words, with head/tail pointers of DEPTH_LOG bits and a count of DEPTH_LOG+1 bits. empty = (count==0); full = (count==2^DEPTH_LOG).
- Push when rdy_in && fetch_valid && fetch_ready && !flush_pipline. The word is written at tail and tail increments mod depth.
- Issue when rdy_in && !empty && !rs_full && !rob_full && !flush_pipline. On that edge:
  - ins_issued <= mem[head]
  - ins_id <= next_id
  - ins_just_issued <= 1
  - head increments mod depth
  - next_id increments mod 2^ID_WIDTH, so 31 wraps to 0.
- If no issue occurs on an edge with rdy_in high, ins_just_issued <= 0. ins_issued and ins_id hold their last values.
- Count update: push and issue on the same edge leaves count unchanged. Push alone gives +1; issue alone gives -1.
- fetch_ready ignores a same-cycle issue. When full, a push is refused even if an issue occurs on that edge.
- Flush, sampled only while rdy_in is high, has top priority:
  - head, tail and count become 0; next_id becomes 0; ins_just_issued becomes 0.
  - Any same-cycle push or issue is suppressed.
  - ins_issued and ins_id hold.
- rdy_in low: no register changes. A flush asserted only while rdy_in is low is lost. fetch_ready still reflects !full.
- Reset, asynchronous on rst_in low: ins_just_issued=0, ins_issued=0, ins_id=0, queue_count=0, next_id=0, head=tail=0. Therefore fetch_ready=1. Releasing reset mid-operation starts from an empty queue.

## Timing
- Minimum latency: a word pushed at edge N is at head after edge N. It can issue at edge N+1, so ins_just_issued is high in the cycle following edge N+1. There is no fetch-to-issue bypass.
- Throughput: one push and one issue per cycle in steady state.
- Each ins_just_issued pulse is exactly one cycle per issued instruction. Back-to-back issues keep it high on consecutive cycles, with a new ins_issued/ins_id each cycle.
- rs_full and rob_full are sampled at the issue edge. Deasserting either allows an issue on the very next edge.
- Flush at edge F: ins_just_issued is 0 after F, and fetch_ready=1 after F. The first post-flush push can happen at edge F+1 and issues with id 0 at edge F+2 at the earliest.

## Test plan
- Reset then single push: assert rst_in=0, release, push 0x00500093 at edge 1. ins_just_issued rises after edge 2 with ins_issued=0x00500093 and ins_id=0. All outputs read 0 during reset.
- Fill and back-pressure: hold rs_full=1 and push 5 words A..E. fetch_ready drops after the 4th push, E is refused, and queue_count=4. Release rs_full: A..D issue on 4 consecutive edges with ids 0..3, in order.
- Id wrap-around: issue 33 instructions continuously. ids run 0..31 then 0. A simultaneous push and issue at full occupancy-1 keeps count constant.
- ROB stall: with 2 queued and rob_full=1 for 3 cycles, no strobe appears. One edge after rob_full falls, the next id is issued.
- Flush mid-stream: with 3 queued and fetch_valid=1, assert flush_pipline for one cycle. queue_count=0, the strobe is low, and the same-cycle push is dropped. The next pushed word issues with ins_id=0.
- rdy_in pause: drop rdy_in for 4 cycles during streaming. The strobe, count and ids are frozen, and a flush pulse in that window has no effect. The stream resumes identically when rdy_in returns high.
